// File: rtl/chan_mux_seq_if.sv
// Channel-selector bus: packed channel words and controls in, selected word and scan status out.
// The "master" side drives channel data and controls; the selector itself uses the "slave" side.
interface chan_mux_seq_if #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
);
   logic [CHANNELS*WIDTH-1:0] din;
   logic [SEL_W-1:0]          sel;
   logic                      mode;
   logic                      start;
   logic                      out_ready;
   logic [WIDTH-1:0]          y;
   logic [SEL_W-1:0]          y_sel;
   logic                      y_valid;
   logic                      y_last;
   logic                      busy;

   modport master (
      output din, sel, mode, start, out_ready,
      input  y, y_sel, y_valid, y_last, busy
   );

   modport slave (
      input  din, sel, mode, start, out_ready,
      output y, y_sel, y_valid, y_last, busy
   );
endinterface

// File: rtl/chan_mux_seq.sv
// Registered N:1 channel word selector with a snapshot-and-stream scan mode that
// feeds the shared multiply-accumulate stage one word per accepted beat.
module chan_mux_seq #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input logic           clk,
   input logic           rst_n,
   chan_mux_seq_if.slave bus
);

   // Word arrays span the whole select range so any SEL_W index is in bounds;
   // entries past the last channel mirror the last channel.
   localparam int               DEPTH    = 2 ** SEL_W;
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t           state_reg,   state_next;
   logic [SEL_W-1:0] idx_reg,     idx_next;
   logic [WIDTH-1:0] y_reg,       y_next;
   logic [SEL_W-1:0] y_sel_reg,   y_sel_next;
   logic             y_valid_reg, y_valid_next;
   logic             y_last_reg,  y_last_next;
   logic             busy_reg,    busy_next;

   logic [WIDTH-1:0] din_word    [DEPTH];
   logic [WIDTH-1:0] capture_reg [DEPTH];
   logic             snapshot_en;
   logic [SEL_W-1:0] sel_clamped;
   logic [SEL_W-1:0] idx_inc;
   logic             accept;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      if (gi < CHANNELS) begin : g_live
         assign din_word[gi] = bus.din[gi*WIDTH +: WIDTH];
      end else begin : g_pad
         assign din_word[gi] = bus.din[(CHANNELS-1)*WIDTH +: WIDTH];
      end
   end

   // Out-of-range manual selects fall back to the highest real channel.
   assign sel_clamped = (bus.sel > LAST_IDX) ? LAST_IDX : bus.sel;
   assign idx_inc     = idx_reg + SEL_W'(1);
   assign accept      = y_valid_reg && bus.out_ready;

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      y_next       = y_reg;
      y_sel_next   = y_sel_reg;
      y_valid_next = y_valid_reg;
      y_last_next  = y_last_reg;
      busy_next    = busy_reg;
      snapshot_en  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (!bus.mode) begin
               y_next       = din_word[sel_clamped];
               y_sel_next   = sel_clamped;
               y_valid_next = 1'b1;
               y_last_next  = 1'b0;
            end else if (bus.start) begin
               snapshot_en  = 1'b1;
               idx_next     = '0;
               y_next       = din_word[0];
               y_sel_next   = '0;
               y_valid_next = 1'b1;
               y_last_next  = (CHANNELS == 1);
               busy_next    = 1'b1;
               state_next   = SCAN;
            end else begin
               y_valid_next = 1'b0;
               y_last_next  = 1'b0;
            end
         end

         SCAN: begin
            // Outputs hold until the downstream stage takes the current word.
            if (accept) begin
               if (idx_reg == LAST_IDX) begin
                  y_valid_next = 1'b0;
                  y_last_next  = 1'b0;
                  busy_next    = 1'b0;
                  idx_next     = '0;
                  state_next   = IDLE;
               end else begin
                  idx_next    = idx_inc;
                  y_next      = capture_reg[idx_inc];
                  y_sel_next  = idx_inc;
                  y_last_next = (idx_inc == LAST_IDX);
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         y_reg       <= '0;
         y_sel_reg   <= '0;
         y_valid_reg <= 1'b0;
         y_last_reg  <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         y_reg       <= y_next;
         y_sel_reg   <= y_sel_next;
         y_valid_reg <= y_valid_next;
         y_last_reg  <= y_last_next;
         busy_reg    <= busy_next;
      end
   end

   // Snapshot taken at scan start so later din changes cannot leak into the stream.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            capture_reg[i] <= '0;
         end
      end else if (snapshot_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            capture_reg[i] <= din_word[i];
         end
      end
   end

   assign bus.y       = y_reg;
   assign bus.y_sel   = y_sel_reg;
   assign bus.y_valid = y_valid_reg;
   assign bus.y_last  = y_last_reg;
   assign bus.busy    = busy_reg;

endmodule

// File: tb/tb_chan_mux_seq.sv
// Bench for chan_mux_seq: 4-, 3- and 1-channel instances driven in lockstep and
// compared every cycle against a word-list reference model, plus directed spot checks.
module tb_chan_mux_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   chan_mux_seq_if #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) bus4 ();
   chan_mux_seq_if #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) bus3 ();
   chan_mux_seq_if #(.WIDTH(4), .CHANNELS(1), .SEL_W(2)) bus1 ();

   chan_mux_seq #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
   chan_mux_seq #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
   chan_mux_seq #(.WIDTH(4), .CHANNELS(1), .SEL_W(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   // Shared stimulus
   logic [3:0] word [4];
   logic [1:0] sel;
   logic       mode, start, ordy;

   int cmp_count = 0;
   int err_count = 0;
   int cyc = 0;

   // Reference model: per instance, the snapshot list and how many words are still owed.
   int chs [3] = '{4, 3, 1};
   int m_snap [3][4];
   int m_left [3];
   int m_y [3], m_ysel [3], m_yv [3], m_yl [3], m_busy [3];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      cmp_count++;
      if (got !== exp) begin
         err_count++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic apply();
      bus4.din       = {word[3], word[2], word[1], word[0]};
      bus3.din       = {word[2], word[1], word[0]};
      bus1.din       = word[0];
      bus4.sel       = sel;  bus3.sel       = sel;  bus1.sel       = sel;
      bus4.mode      = mode; bus3.mode      = mode; bus1.mode      = mode;
      bus4.start     = start; bus3.start    = start; bus1.start    = start;
      bus4.out_ready = ordy; bus3.out_ready = ordy; bus1.out_ready = ordy;
   endtask

   task automatic model_edge();
      for (int d = 0; d < 3; d++) begin
         int n;
         int s;
         n = chs[d];
         if (!rst_n) begin
            m_y[d] = 0; m_ysel[d] = 0; m_yv[d] = 0; m_yl[d] = 0; m_busy[d] = 0; m_left[d] = 0;
         end else if (m_busy[d] != 0) begin
            if (m_yv[d] != 0 && ordy) begin
               m_left[d] = m_left[d] - 1;
               if (m_left[d] == 0) begin
                  m_yv[d] = 0; m_yl[d] = 0; m_busy[d] = 0;
               end else begin
                  m_ysel[d] = n - m_left[d];
                  m_y[d]    = m_snap[d][m_ysel[d]];
                  m_yl[d]   = (m_left[d] == 1) ? 1 : 0;
               end
            end
         end else if (!mode) begin
            s = 32'(sel);
            if (s >= n) s = n - 1;
            m_y[d] = 32'(word[s]); m_ysel[d] = s; m_yv[d] = 1; m_yl[d] = 0;
         end else if (start) begin
            for (int i = 0; i < n; i++) m_snap[d][i] = 32'(word[i]);
            m_left[d] = n;
            m_y[d] = m_snap[d][0]; m_ysel[d] = 0; m_yv[d] = 1;
            m_yl[d] = (n == 1) ? 1 : 0; m_busy[d] = 1;
         end else begin
            m_yv[d] = 0; m_yl[d] = 0;
         end
      end
   endtask

   task automatic compare_all();
      check_val("c4_y",     32'(bus4.y),       m_y[0]);
      check_val("c4_ysel",  32'(bus4.y_sel),   m_ysel[0]);
      check_val("c4_valid", 32'(bus4.y_valid), m_yv[0]);
      check_val("c4_last",  32'(bus4.y_last),  m_yl[0]);
      check_val("c4_busy",  32'(bus4.busy),    m_busy[0]);
      check_val("c3_y",     32'(bus3.y),       m_y[1]);
      check_val("c3_ysel",  32'(bus3.y_sel),   m_ysel[1]);
      check_val("c3_valid", 32'(bus3.y_valid), m_yv[1]);
      check_val("c3_last",  32'(bus3.y_last),  m_yl[1]);
      check_val("c3_busy",  32'(bus3.busy),    m_busy[1]);
      check_val("c1_y",     32'(bus1.y),       m_y[2]);
      check_val("c1_ysel",  32'(bus1.y_sel),   m_ysel[2]);
      check_val("c1_valid", 32'(bus1.y_valid), m_yv[2]);
      check_val("c1_last",  32'(bus1.y_last),  m_yl[2]);
      check_val("c1_busy",  32'(bus1.busy),    m_busy[2]);
   endtask

   // One clock: present inputs, advance the model, sample the DUTs just after the edge.
   task automatic step();
      apply();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      compare_all();
   endtask

   task automatic set_abcd();
      word[0] = 4'hA; word[1] = 4'hB; word[2] = 4'hC; word[3] = 4'hD;
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         m_left[d] = 0; m_y[d] = 0; m_ysel[d] = 0; m_yv[d] = 0; m_yl[d] = 0; m_busy[d] = 0;
         for (int i = 0; i < 4; i++) m_snap[d][i] = 0;
      end

      // Reset with random inputs
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) word[i] = 4'($urandom);
         sel = 2'($urandom); mode = 1'($urandom); start = 1'($urandom); ordy = 1'($urandom);
         step();
         check_val("rst_valid", 32'(bus4.y_valid), 0);
         check_val("rst_busy", 32'(bus4.busy), 0);
      end
      rst_n = 1'b1;

      // Manual select
      set_abcd();
      mode = 1'b0; start = 1'b0; ordy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sel = 2'(i);
         step();
         check_val("man_y", 32'(bus4.y), 10 + i);
         check_val("man_ysel", 32'(bus4.y_sel), i);
      end
      check_val("clamp_y", 32'(bus3.y), 12);
      check_val("clamp_ysel", 32'(bus3.y_sel), 2);

      // Scan at full rate
      mode = 1'b1; start = 1'b1; ordy = 1'b1;
      step();
      start = 1'b0;
      for (int j = 0; j < 4; j++) begin
         check_val("scan_y", 32'(bus4.y), 10 + j);
         check_val("scan_last", 32'(bus4.y_last), (j == 3) ? 1 : 0);
         check_val("scan_busy", 32'(bus4.busy), 1);
         step();
      end
      check_val("scan_end_valid", 32'(bus4.y_valid), 0);
      check_val("scan_end_busy", 32'(bus4.busy), 0);

      // Backpressure, mid-scan restart and snapshot isolation
      start = 1'b1; ordy = 1'b0;
      step();
      for (int j = 0; j < 3; j++) begin
         start = (j == 1);
         step();
         check_val("bp_y", 32'(bus4.y), 10);
         check_val("bp_valid", 32'(bus4.y_valid), 1);
      end
      start = 1'b0; ordy = 1'b1;
      for (int i = 0; i < 4; i++) word[i] = 4'h0;
      for (int j = 1; j < 4; j++) begin
         step();
         check_val("snap_y", 32'(bus4.y), 10 + j);
      end
      step();

      // Start coinciding with the final accept is ignored
      set_abcd();
      start = 1'b1; ordy = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      check_val("fin_last", 32'(bus4.y_last), 1);
      start = 1'b1;
      step();
      check_val("fin_busy", 32'(bus4.busy), 0);
      check_val("fin_valid", 32'(bus4.y_valid), 0);
      start = 1'b0;
      step();
      check_val("fin_idle", 32'(bus4.busy), 0);

      // Reset in the middle of a scan
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      check_val("abort_preB", 32'(bus4.y), 11);
      rst_n = 1'b0;
      step();
      check_val("abort_y", 32'(bus4.y), 0);
      check_val("abort_busy", 32'(bus4.busy), 0);
      rst_n = 1'b1;

      // Randomized traffic
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < 4; i++) word[i] = 4'($urandom);
         sel   = 2'($urandom);
         mode  = ($urandom_range(0, 3) != 0);
         start = ($urandom_range(0, 2) == 0);
         ordy  = ($urandom_range(0, 9) < 6);
         rst_n = ($urandom_range(0, 59) != 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule
